// File: rtl/mtl2_touch_int_conditioner.sv
// mtl2_touch_int_conditioner
//
// Cleans up the raw touch-interrupt line from the MTL2 panel before it reaches
// the touch-interrupt PIO. The raw pin is synchronised, glitches shorter than
// FILTER_CYCLES are rejected, and each qualified touch produces exactly one
// active-low pulse of PULSE_CYCLES clocks. A holdoff window then blocks
// re-triggering until it has elapsed and the line has been released.
// A wrapping event counter and a stuck-low flag are kept for diagnostics.
//
// Ports:
//   clk              single clock, shared with the PIO
//   reset_n          synchronous, active-low reset
//   touch_int_n_raw  asynchronous panel interrupt, active low
//   clr_count        one-cycle pulse, clears event_count
//   int_n_out        conditioned interrupt, idle high (registered)
//   busy             FSM is not in IDLE (registered)
//   event_count      number of qualified touches, wraps (registered)
//   stuck            synchronised input low for >= STUCK_CYCLES (registered)

module mtl2_touch_int_conditioner #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_CYCLES  = 16,
  parameter int PULSE_CYCLES   = 64,
  parameter int HOLDOFF_CYCLES = 1024,
  parameter int STUCK_CYCLES   = 65536,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             touch_int_n_raw,
  input  logic             clr_count,
  output logic             int_n_out,
  output logic             busy,
  output logic [CNT_W-1:0] event_count,
  output logic             stuck
);

  // Shared phase counter must hold the largest of the three durations.
  localparam int MAX_AB  = (FILTER_CYCLES > PULSE_CYCLES) ? FILTER_CYCLES : PULSE_CYCLES;
  localparam int MAX_CYC = (MAX_AB > HOLDOFF_CYCLES) ? MAX_AB : HOLDOFF_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam int SW      = $clog2(STUCK_CYCLES + 1);

  localparam logic [CW-1:0] FILT_LAST  = CW'(FILTER_CYCLES - 1);
  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_MAX   = CW'(HOLDOFF_CYCLES);
  localparam logic [SW-1:0] STUCK_MAX  = SW'(STUCK_CYCLES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUALIFY = 2'd1,
    PULSE   = 2'd2,
    HOLDOFF = 2'd3
  } state_t;

  state_t state_reg, state_next;

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   s_low;
  logic [CW-1:0]          cnt_reg, cnt_next;
  logic                   count_inc;
  logic [CNT_W-1:0]       event_count_reg, event_count_next;
  logic [SW-1:0]          stuck_cnt_reg, stuck_cnt_next;
  logic                   stuck_reg;
  logic                   int_n_reg;
  logic                   busy_reg;

  // Synchroniser: stage 0 samples the pin, the last stage feeds the logic.
  // Stages reset high so reset never looks like a touch.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_reg <= '1;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], touch_int_n_raw};
    end
  end

  assign s_low = ~sync_reg[SYNC_STAGES-1];

  // Next-state logic. count_inc marks the single edge on which PULSE is
  // entered; that edge drops int_n_out and bumps event_count together.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    count_inc  = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (s_low) begin
          if (FILTER_CYCLES == 1) begin
            state_next = PULSE;
            cnt_next   = '0;
            count_inc  = 1'b1;
          end else begin
            state_next = QUALIFY;
            cnt_next   = CW'(1);
          end
        end
      end
      QUALIFY: begin
        if (!s_low) begin
          // Glitch: line came back before the filter time elapsed.
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == FILT_LAST) begin
          state_next = PULSE;
          cnt_next   = '0;
          count_inc  = 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      PULSE: begin
        if (cnt_reg == PULSE_LAST) begin
          state_next = HOLDOFF;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      HOLDOFF: begin
        // Saturate at HOLD_MAX, then wait for the line to be released so a
        // line held low yields only one pulse.
        if (cnt_reg == HOLD_MAX) begin
          if (!s_low) begin
            state_next = IDLE;
            cnt_next   = '0;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Clear first, then count, so a coincident clear and touch leaves 1.
  always_comb begin
    event_count_next = clr_count ? '0 : event_count_reg;
    if (count_inc) begin
      event_count_next = event_count_next + 1'b1;
    end
  end

  // Stuck detector: saturating run length of synchronised-low cycles.
  always_comb begin
    stuck_cnt_next = '0;
    if (s_low) begin
      stuck_cnt_next = (stuck_cnt_reg == STUCK_MAX) ? stuck_cnt_reg : stuck_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      int_n_reg       <= 1'b1;
      busy_reg        <= 1'b0;
      event_count_reg <= '0;
      stuck_cnt_reg   <= '0;
      stuck_reg       <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      // Outputs are registered from the next state so they change on the
      // same edge as the state itself.
      int_n_reg       <= (state_next != PULSE);
      busy_reg        <= (state_next != IDLE);
      event_count_reg <= event_count_next;
      stuck_cnt_reg   <= stuck_cnt_next;
      stuck_reg       <= (stuck_cnt_next == STUCK_MAX);
    end
  end

  assign int_n_out   = int_n_reg;
  assign busy        = busy_reg;
  assign event_count = event_count_reg;
  assign stuck       = stuck_reg;

endmodule

// File: tb/tb_mtl2_touch_int_conditioner.sv
// tb_mtl2_touch_int_conditioner
//
// Self-checking bench for mtl2_touch_int_conditioner. Every clock the DUT
// outputs are compared with a behavioural model that works on the history of
// synchronised samples: a run of FILTER_CYCLES low samples while ready starts
// a pulse at that edge, the pulse lasts PULSE_CYCLES edges, and readiness
// returns one edge after the first released sample that follows the holdoff
// window. Directed scenarios add explicit timing and counting checks.
// Small STUCK_CYCLES and CNT_W keep the run short.

module tb_mtl2_touch_int_conditioner;

  localparam int SYNC   = 2;
  localparam int FILT   = 16;
  localparam int PULSEC = 64;
  localparam int HOLD   = 1024;
  localparam int STUCKC = 4096;
  localparam int CW     = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          raw;
  logic          clr_count;
  logic          int_n_out;
  logic          busy;
  logic [CW-1:0] event_count;
  logic          stuck;

  mtl2_touch_int_conditioner #(
    .SYNC_STAGES   (SYNC),
    .FILTER_CYCLES (FILT),
    .PULSE_CYCLES  (PULSEC),
    .HOLDOFF_CYCLES(HOLD),
    .STUCK_CYCLES  (STUCKC),
    .CNT_W         (CW)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .touch_int_n_raw(raw),
    .clr_count      (clr_count),
    .int_n_out      (int_n_out),
    .busy           (busy),
    .event_count    (event_count),
    .stuck          (stuck)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int t        = 0;

  // Reference model state
  bit hist[$];
  int run_len;
  int srun;
  int ec;
  int fall_t;
  bit holding;
  bit e_int, e_busy, e_stuck;

  // PIO-style observation of int_n_out
  bit last_int = 1'b1;
  int pio_edges = 0;
  int fall_obs = -1;
  int rise_obs = -1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at edge %0d", tag, got, want, t);
  endtask

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < SYNC; i++) hist.push_back(1'b1);
    run_len = 0;
    srun    = 0;
    ec      = 0;
    fall_t  = -1000000;
    holding = 1'b0;
    e_int   = 1'b1;
    e_busy  = 1'b0;
    e_stuck = 1'b0;
  endtask

  task automatic model_edge();
    bit sl;
    if (!reset_n) begin
      model_reset();
      return;
    end
    sl = !hist.pop_front();
    hist.push_back(raw);
    srun = sl ? ((srun + 1 > STUCKC) ? STUCKC : srun + 1) : 0;
    if (clr_count) ec = 0;
    if (holding) begin
      if (t > fall_t + PULSEC + HOLD && !sl) holding = 1'b0;
    end else begin
      run_len = sl ? run_len + 1 : 0;
      if (run_len == FILT) begin
        fall_t  = t;
        holding = 1'b1;
        run_len = 0;
        ec      = (ec + 1) % (1 << CW);
      end
    end
    e_int   = !(holding && t < fall_t + PULSEC);
    e_busy  = holding || (run_len > 0);
    e_stuck = (srun >= STUCKC);
  endtask

  task automatic step();
    logic [CW-1:0] ecb;
    @(posedge clk);
    t++;
    model_edge();
    #1;
    ecb = ec[CW-1:0];
    check_eq("cyc", 32'({int_n_out, busy, stuck, event_count}),
             32'({e_int, e_busy, e_stuck, ecb}));
    if (last_int && !int_n_out) begin
      pio_edges++;
      fall_obs = t;
    end
    if (!last_int && int_n_out) rise_obs = t;
    last_int = int_n_out;
  endtask

  task automatic idle(input int n);
    raw = 1'b1;
    repeat (n) step();
  endtask

  task automatic touch(input int len);
    raw = 1'b0;
    repeat (len) step();
    raw = 1'b1;
  endtask

  initial begin
    int n0, p0, f1, r_edge, t_stop;
    logic [CW-1:0] c0;

    model_reset();
    reset_n   = 1'b0;
    raw       = 1'b1;
    clr_count = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;

    // Idle line
    idle(100);
    check_eq("idle_int", 32'(int_n_out), 32'd1);
    check_eq("idle_busy", 32'(busy), 32'd0);
    check_eq("idle_cnt", 32'(event_count), 32'd0);
    check_eq("idle_stuck", 32'(stuck), 32'd0);

    // Short glitch is rejected
    touch(10);
    idle(40);
    check_eq("glitch_cnt", 32'(event_count), 32'd0);
    check_eq("glitch_busy", 32'(busy), 32'd0);
    check_eq("glitch_pio", 32'(pio_edges), 32'd0);

    // Single qualified touch: latency and width
    raw = 1'b0;
    step();
    n0 = t;
    repeat (19) step();
    raw = 1'b1;
    idle(1200);
    check_eq("lat", 32'(fall_obs - n0), 32'(SYNC + FILT - 1));
    check_eq("width", 32'(rise_obs - fall_obs), 32'(PULSEC));
    check_eq("one_cnt", 32'(event_count), 32'd1);
    check_eq("one_pio", 32'(pio_edges), 32'd1);

    // Line held low: one pulse, stuck sets, clears after release
    p0 = pio_edges;
    touch(STUCKC + 1100);
    check_eq("hold_pio", 32'(pio_edges - p0), 32'd1);
    check_eq("hold_stuck", 32'(stuck), 32'd1);
    check_eq("hold_busy", 32'(busy), 32'd1);
    raw = 1'b1;
    step();
    r_edge = t;
    step();
    check_eq("stuck_r1", 32'(stuck), 32'd1);
    step();
    check_eq("stuck_r2", 32'(stuck), 32'd0);
    check_eq("stuck_lag", 32'(t - r_edge), 32'(SYNC));
    idle(20);
    touch(20);
    idle(1200);
    check_eq("after_rel_pio", 32'(pio_edges - p0), 32'd2);

    // Two touches 200 apart: second falls into holdoff
    c0 = event_count;
    touch(20);
    idle(180);
    touch(20);
    idle(1200);
    check_eq("pair200", 32'(CW'(event_count - c0)), 32'd1);

    // Two touches 1200 apart: both accepted
    c0 = event_count;
    touch(20);
    idle(1180);
    f1 = fall_obs;
    touch(20);
    idle(1200);
    check_eq("pair1200", 32'(CW'(event_count - c0)), 32'd2);
    check_eq("spacing", 32'((fall_obs - f1) >= (PULSEC + HOLD + FILT)), 32'd1);

    // Counter wrap
    clr_count = 1'b1;
    step();
    clr_count = 1'b0;
    check_eq("clr_only", 32'(event_count), 32'd0);
    for (int i = 0; i < (1 << CW) - 1; i++) begin
      touch(20);
      idle(1200);
    end
    check_eq("pre_wrap", 32'(event_count), 32'((1 << CW) - 1));
    touch(20);
    idle(1200);
    check_eq("wrap", 32'(event_count), 32'd0);

    // Clear coincident with an increment leaves 1
    touch(3);
    idle(5);
    c0 = event_count;
    raw = 1'b0;
    step();
    n0 = t;
    repeat (SYNC + FILT - 2) step();
    clr_count = 1'b1;
    step();
    clr_count = 1'b0;
    check_eq("clr_inc_edge", 32'(fall_obs - n0), 32'(SYNC + FILT - 1));
    check_eq("clr_inc", 32'(event_count), 32'd1);
    repeat (2) step();
    idle(1200);

    // Reset in the middle of a pulse
    touch(20);
    idle(5);
    check_eq("mid_low", 32'(int_n_out), 32'd0);
    reset_n = 1'b0;
    step();
    check_eq("rst_mid_int", 32'(int_n_out), 32'd1);
    check_eq("rst_mid_cnt", 32'(event_count), 32'd0);
    check_eq("rst_mid_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    idle(100);
    check_eq("post_rst_cnt", 32'(event_count), 32'd0);

    // Randomised traffic against the model
    t_stop = t + 15000;
    while (t < t_stop) begin
      int lo, hi;
      lo = int'($urandom_range(40, 1));
      hi = int'($urandom_range(1400, 1));
      raw = 1'b0;
      repeat (lo) begin
        clr_count = ($urandom_range(99, 0) == 0);
        step();
      end
      raw = 1'b1;
      repeat (hi) begin
        clr_count = ($urandom_range(99, 0) == 0);
        step();
      end
    end
    clr_count = 1'b0;
    idle(10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
